irq_stim_gen: RTL
=================

IRQ_STIM_GEN -- requirements
Module: irq_stim_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of independent interrupt channels, legal 1..8.
REQ-002 SHALL have parameter CNT_W, default 16: period counter width.
REQ-003 SHALL have parameter BASE_IRQ, default 4: channel i drives irq[BASE_IRQ+i]; BASE_IRQ+NUM_CH <= 32.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port resetn, input, 1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port en, input, 1: global enable; low freezes all counters.
REQ-007 SHALL have port cfg_valid, input, 1: configuration write strobe.
REQ-008 SHALL have port cfg_ready, output, 1: constant 1 outside reset; a write completes when cfg_valid is high on a clock edge.
REQ-009 SHALL have port cfg_ch, input, 3: target channel; values >= NUM_CH are ignored.
REQ-010 SHALL have port cfg_period, input, CNT_W: period in cycles; 0 disables the channel.
REQ-011 SHALL have port cfg_level, input, 1: 0 = pulse mode, 1 = level mode.
REQ-012 SHALL have port irq_ack, input, 32: per-bit acknowledge from the core (eoi).
REQ-013 SHALL have port irq, output, 32: interrupt vector to the core; bits outside the channel range tie to 0.

Function
REQ-014 Each channel SHALL implement FSM OFF / COUNT / PEND.
REQ-015 OFF: counter at 0, irq bit low; a write with period P != 0 moves to COUNT with counter 0.
REQ-016 COUNT with en high: counter increments by 1; when counter == P-1 it SHALL fire and reload to 0, giving one fire every P enabled cycles (first fire P cycles after the write).
REQ-017 Pulse mode fire: irq bit high for exactly one cycle, registered (bit high in the cycle after counter == P-1 is sampled); FSM stays in COUNT.
REQ-018 Level mode fire: irq bit goes high and FSM enters PEND; counting continues in PEND.
REQ-019 PEND: irq bit held high until irq_ack bit sampled high, then low next cycle and FSM returns to COUNT.
REQ-020 PEND: a fire in PEND is a missed event; irq stays high.
REQ-021 Fire and ack in the same cycle: fire wins; irq stays high; no miss recorded.
REQ-022 en low: counters hold, no fires, PEND state and held level bits retained, pulse bits forced low.
REQ-023 Config write: counter reloads to 0, pending cleared, irq bit low next cycle, new mode/period take effect immediately; period 0 enters OFF.
REQ-024 Simultaneous write and fire on the same channel: write wins; the fire is discarded.
REQ-025 irq_ack on bits not in PEND SHALL have no effect.

Reset
REQ-026 resetn low SHALL asynchronously force all channels to OFF, counters 0, periods 0, modes pulse, irq = 0, cfg_ready = 0, miss counters 0.
REQ-027 Reset mid-PEND or mid-pulse SHALL drop irq within the same cycle, with no residual pulse after release.
REQ-028 cfg_ready SHALL rise on the first clock edge after resetn is released.

Configuration
REQ-029 Macro IRQ_STIM_MISS_CNT_EN: when defined, each channel keeps an 8-bit saturating miss counter (max 255) exposed on output miss_cnt [NUM_CH*8], cleared by a config write to that channel; when undefined, miss_cnt does not exist and misses are not recorded.

Structure
REQ-030 Package irq_stim_pkg SHALL hold the channel state enum (OFF, COUNT, PEND), MISS_W = 8, and the maximum NUM_CH = 8.
REQ-031 Per-channel logic SHALL live in sub-module irq_stim_chan, instantiated NUM_CH times by a generate loop.

Verification
REQ-032 Ch0 pulse mode, P=8192, en=1: irq[4] is high for 1 cycle at 8192, 16384 and 24576 cycles after the write; otherwise low.
REQ-033 Ch1 level mode, P=100, no ack for 250 cycles: irq[5] rises at cycle 100 and stays high; miss_cnt[15:8] = 1 at 200 (with MISS_CNT_EN); ack at 250 drops irq[5] at 251.
REQ-034 Ack coincident with a fire (P=10, ack at cycle 20): irq stays high and miss_cnt is unchanged.
REQ-035 en low for 50 cycles mid-count (P=64, en drops at 30): the fire occurs at cycle 114, not 64.
REQ-036 Write P=0 to ch0 while pending: irq[4] falls next cycle and the channel stays silent for 10000 cycles.
REQ-037 resetn pulsed low during a level pend: irq = 0 immediately; after release all channels are OFF and cfg_ready = 1 one edge later.

Source files
------------

// File: rtl/irq_stim_pkg.sv
// irq_stim_pkg
// Shared definitions for the interrupt stimulus generator: the per-channel
// state encoding, the width of the optional miss counters and the largest
// supported channel count.
// Optional feature macro: IRQ_STIM_MISS_CNT_EN (miss counters, see top).
package irq_stim_pkg;

   localparam int MISS_W     = 8;
   localparam int MAX_NUM_CH = 8;

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_COUNT = 2'd1,
      ST_PEND  = 2'd2
   } chan_state_e;

endpackage

// File: rtl/irq_stim_gen_if.sv
// irq_stim_gen_if
// Configuration write channel of the interrupt stimulus generator.
//   cfg_valid  : write strobe (master -> slave)
//   cfg_ready  : slave can accept writes (slave -> master)
//   cfg_ch     : target channel index
//   cfg_period : period in cycles, 0 disables the channel
//   cfg_level  : 0 = pulse mode, 1 = level mode
interface irq_stim_gen_if #(
   parameter int CNT_W = 16
);

   logic             cfg_valid;
   logic             cfg_ready;
   logic [2:0]       cfg_ch;
   logic [CNT_W-1:0] cfg_period;
   logic             cfg_level;

   modport master (
      output cfg_valid, cfg_ch, cfg_period, cfg_level,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid, cfg_ch, cfg_period, cfg_level,
      output cfg_ready
   );

endinterface

// File: rtl/irq_stim_chan.sv
// irq_stim_chan
// One periodic interrupt source with OFF / COUNT / PEND behaviour.
// Ports:
//   clk, resetn : clock, asynchronous active-low reset
//   en_i        : global enable, low freezes the counter
//   wr_i        : configuration write aimed at this channel
//   period_i    : new period (0 = off)
//   level_i     : new mode (0 = pulse, 1 = level)
//   ack_i       : acknowledge for this channel's interrupt bit
//   irq_o       : registered interrupt output
//   miss_o      : saturating missed-event count (IRQ_STIM_MISS_CNT_EN only)
module irq_stim_chan
   import irq_stim_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             en_i,
   input  logic             wr_i,
   input  logic [CNT_W-1:0] period_i,
   input  logic             level_i,
   input  logic             ack_i,
   output logic             irq_o
`ifdef IRQ_STIM_MISS_CNT_EN
   ,
   output logic [MISS_W-1:0] miss_o
`endif
);

   chan_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic             level_q, level_d;
   logic             irq_q, irq_d;
   logic             fire;
`ifdef IRQ_STIM_MISS_CNT_EN
   logic [MISS_W-1:0] miss_q, miss_d;
`endif

   // A write overrides everything in the same cycle, including a coincident
   // fire. In PEND a fire together with an ack keeps the bit high and is not
   // counted as a miss, since the core is just servicing the previous event.
   always_comb begin
      fire     = en_i && (state_q != ST_OFF) && (cnt_q == period_q - 1'b1);
      state_d  = state_q;
      cnt_d    = cnt_q;
      period_d = period_q;
      level_d  = level_q;
      irq_d    = irq_q;
`ifdef IRQ_STIM_MISS_CNT_EN
      miss_d   = miss_q;
`endif
      if (wr_i) begin
         period_d = period_i;
         level_d  = level_i;
         cnt_d    = '0;
         irq_d    = 1'b0;
         state_d  = (period_i != '0) ? ST_COUNT : ST_OFF;
`ifdef IRQ_STIM_MISS_CNT_EN
         miss_d   = '0;
`endif
      end else begin
         if ((state_q != ST_OFF) && en_i) begin
            cnt_d = fire ? '0 : cnt_q + 1'b1;
         end
         case (state_q)
            ST_COUNT: begin
               irq_d = fire;
               if (fire && level_q) begin
                  state_d = ST_PEND;
               end
            end
            ST_PEND: begin
               if (fire) begin
                  irq_d = 1'b1;
`ifdef IRQ_STIM_MISS_CNT_EN
                  if (!ack_i && (miss_q != '1)) begin
                     miss_d = miss_q + 1'b1;
                  end
`endif
               end else if (ack_i) begin
                  irq_d   = 1'b0;
                  state_d = ST_COUNT;
               end
            end
            default: begin
               irq_d = 1'b0;
            end
         endcase
      end
   end

   // Channel state registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= ST_OFF;
         cnt_q    <= '0;
         period_q <= '0;
         level_q  <= 1'b0;
         irq_q    <= 1'b0;
`ifdef IRQ_STIM_MISS_CNT_EN
         miss_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         period_q <= period_d;
         level_q  <= level_d;
         irq_q    <= irq_d;
`ifdef IRQ_STIM_MISS_CNT_EN
         miss_q   <= miss_d;
`endif
      end
   end

   assign irq_o = irq_q;
`ifdef IRQ_STIM_MISS_CNT_EN
   assign miss_o = miss_q;
`endif

endmodule

// File: rtl/irq_stim_gen.sv
// irq_stim_gen
// Bank of NUM_CH periodic interrupt sources; channel i drives
// irq[BASE_IRQ+i] and is acknowledged through irq_ack[BASE_IRQ+i].
// Ports:
//   clk, resetn : clock, asynchronous active-low reset
//   en          : global enable
//   cfg         : configuration write channel (irq_stim_gen_if.slave)
//   irq_ack     : per-bit acknowledge from the core
//   irq         : interrupt vector, bits outside the channel range are 0
//   miss_cnt    : 8 bits per channel of missed events
//                 (present only when IRQ_STIM_MISS_CNT_EN is defined)
module irq_stim_gen
   import irq_stim_pkg::*;
#(
   parameter int NUM_CH   = 2,
   parameter int CNT_W    = 16,
   parameter int BASE_IRQ = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        en,
   irq_stim_gen_if.slave cfg,
   input  logic [31:0] irq_ack,
   output logic [31:0] irq
`ifdef IRQ_STIM_MISS_CNT_EN
   ,
   output logic [NUM_CH*MISS_W-1:0] miss_cnt
`endif
);

   logic              ready_q;
   logic [NUM_CH-1:0] chIrq;
   logic              unused_ack;

   // Ready is low throughout reset and rises on the first edge after release
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ready_q <= 1'b0;
      end else begin
         ready_q <= 1'b1;
      end
   end

   assign cfg.cfg_ready = ready_q;

   // Channel indices >= NUM_CH match no instance, so such writes are dropped
   for (genvar i = 0; i < NUM_CH; i++) begin : gChan
      irq_stim_chan #(
         .CNT_W (CNT_W)
      ) uChan (
         .clk      (clk),
         .resetn   (resetn),
         .en_i     (en),
         .wr_i     (cfg.cfg_valid && (cfg.cfg_ch == 3'(i))),
         .period_i (cfg.cfg_period),
         .level_i  (cfg.cfg_level),
         .ack_i    (irq_ack[BASE_IRQ+i]),
         .irq_o    (chIrq[i])
`ifdef IRQ_STIM_MISS_CNT_EN
         ,
         .miss_o   (miss_cnt[i*MISS_W +: MISS_W])
`endif
      );
   end

   // Place the channel bits into the 32-bit vector, everything else tied low
   always_comb begin
      irq = '0;
      irq[BASE_IRQ +: NUM_CH] = chIrq;
   end

   // Acknowledge bits outside the channel range are deliberately ignored
   assign unused_ack = ^irq_ack;

endmodule
